// File: rtl/ext_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer and synchronous flush.
// Optional accepted-transaction counter on perf_cnt when EXT_PERF_CNT_EN is defined.
module ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
`ifdef EXT_PERF_CNT_EN
   output logic [15:0]      perf_cnt,
`endif
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
   // valid never waits on ready, and in_ready depends only on registered state.

   if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("ext_pipe: OUT_W must be at least IN_W+2");
   end

   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_FULL  = 2'b11
   } state_t;

   state_t state_q, state_d;

   logic             accept, send;
   logic             load_main_in, load_main_skid, load_skid;
   logic [OUT_W-1:0] ext_val;
   logic [OUT_W-1:0] main_data, skid_data;
   logic [TAG_W-1:0] main_tag, skid_tag;

   function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm, input logic [1:0] op);
      logic [OUT_W-1:0] sext;
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      case (op)
         2'b00:   return {{(OUT_W-IN_W){1'b0}}, imm};
         2'b01:   return sext;
         2'b10:   return {imm, {(OUT_W-IN_W){1'b0}}};
         default: return sext << 2;
      endcase
   endfunction

   assign ext_val   = extend(in_imm, in_op);
   assign in_ready  = ~state_q[1];
   assign out_valid = state_q[0];
   assign out_data  = main_data;
   assign out_tag   = main_tag;
   assign dbg_state = state_q;
   assign accept    = in_valid & in_ready;
   assign send      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d      = S_ONE;
                  load_main_in = 1'b1;
               end
            end
            S_ONE: begin
               case ({send, accept})
                  2'b11: load_main_in = 1'b1;
                  2'b10: state_d = S_EMPTY;
                  2'b01: begin
                     state_d   = S_FULL;
                     load_skid = 1'b1;
                  end
                  default: state_d = S_ONE;
               endcase
            end
            S_FULL: begin
               if (send) begin
                  state_d        = S_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Data registers are qualified by the valid bits, so a flush leaves them stale.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         main_data <= '0;
         main_tag  <= '0;
         skid_data <= '0;
         skid_tag  <= '0;
      end else begin
         if (load_main_in) begin
            main_data <= ext_val;
            main_tag  <= in_tag;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_tag  <= skid_tag;
         end
         if (load_skid) begin
            skid_data <= ext_val;
            skid_tag  <= in_tag;
         end
      end
   end

`ifdef EXT_PERF_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                  perf_cnt <= '0;
      else if (accept && !flush && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed test-plan cases plus random traffic
// scored against a queue-based reference of the extension rules.
module tb_ext_pipe;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rstn, flush, in_valid, in_ready, out_valid, out_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [OUT_W-1:0] out_data;
   logic [1:0]       dbg_state;
`ifdef EXT_PERF_CNT_EN
   logic [15:0]      perf_cnt, perf_cnt2;
`endif

   // narrow instance
   logic         flush2, in_valid2, in_ready2, out_valid2, out_ready2;
   logic [11:0]  in_imm2;
   logic [1:0]   in_op2, dbg_state2;
   logic [2:0]   in_tag2, out_tag2;
   logic [15:0]  out_data2;

   int n_chk  = 0;
   int n_fail = 0;

   logic [TAG_W+OUT_W-1:0] exp_q[$];
   logic [TAG_W-1:0]       sent_tags[$];
   logic [15:0]            exp_cnt;

   always #5 clk = ~clk;

   ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
`ifdef EXT_PERF_CNT_EN
      .perf_cnt(perf_cnt),
`endif
      .dbg_state(dbg_state)
   );

   ext_pipe #(.IN_W(12), .OUT_W(16), .TAG_W(3)) dut12 (
      .clk(clk), .rstn(rstn), .flush(flush2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2), .in_op(in_op2), .in_tag(in_tag2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_tag(out_tag2),
`ifdef EXT_PERF_CNT_EN
      .perf_cnt(perf_cnt2),
`endif
      .dbg_state(dbg_state2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: signed value of the immediate, scaled with plain integer arithmetic.
   function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] op);
      longint u, s, r;
      u = longint'(imm);
      s = (u >= (64'sd1 <<< (IN_W-1))) ? u - (64'sd1 <<< IN_W) : u;
      case (op)
         2'd0:    r = u;
         2'd1:    r = s;
         2'd2:    r = u * (64'sd1 <<< (OUT_W-IN_W));
         default: r = s * 4;
      endcase
      return OUT_W'(r);
   endfunction

   // Scoreboard: queue occupancy is the model of the buffer.
   always @(negedge clk or negedge rstn) begin
      if (!rstn) begin
         exp_q.delete();
         exp_cnt = 16'd0;
      end else begin
         check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
         check("dbg_state", 64'(dbg_state), {62'd0, exp_q.size() == 2, exp_q.size() > 0});
         if (out_valid && exp_q.size() > 0) begin
            check("out_data", 64'(out_data), 64'(exp_q[0][OUT_W-1:0]));
            check("out_tag", 64'(out_tag), 64'(exp_q[0][TAG_W+OUT_W-1:OUT_W]));
         end
`ifdef EXT_PERF_CNT_EN
         check("perf_cnt", 64'(perf_cnt), 64'(exp_cnt));
`endif
         if (flush) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
               sent_tags.push_back(out_tag);
               void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
               exp_q.push_back({in_tag, ref_ext(in_imm, in_op)});
               if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the item was accepted.
   task automatic put(input logic [1:0] op, input logic [IN_W-1:0] imm, input logic [TAG_W-1:0] tag);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_imm   = imm;
      in_tag   = tag;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) check("put_timeout", 64'd0, 64'd1);
      else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   logic [OUT_W-1:0] b2b_exp [4];
   logic [1:0]       b2b_op  [4];
   logic [IN_W-1:0]  b2b_imm [4];

   initial begin
      b2b_exp = '{32'h0000F000, 32'hFFFFF000, 32'h000F0000, 32'hFFFFFFFC};
      b2b_op  = '{2'd0, 2'd1, 2'd2, 2'd3};
      b2b_imm = '{16'hF000, 16'hF000, 16'h000F, 16'hFFFF};
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_imm = '0; in_op = '0; in_tag = '0;
      flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; in_imm2 = '0; in_op2 = '0; in_tag2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // back-to-back ops, one result per cycle starting one cycle after first accept
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            in_valid = 1'b1; in_op = b2b_op[i]; in_imm = b2b_imm[i]; in_tag = TAG_W'(i);
         end else in_valid = 1'b0;
         @(negedge clk);
         if (i > 0) begin
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_data", 64'(out_data), 64'(b2b_exp[i-1]));
         end
         @(posedge clk); #1;
      end
      drain();

      // backpressure: tags 1,2 accepted, 3 held until the consumer resumes
      sent_tags.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 2'd1; in_imm = 16'h8001; in_tag = 5'd1;
      @(posedge clk); #1;
      in_imm = 16'h1234; in_tag = 5'd2;
      @(posedge clk); #1;
      in_imm = 16'hBEEF; in_tag = 5'd3;
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("bp_hold_tag", 64'(out_tag), 64'd1);
      out_ready = 1'b1;
      put(2'd1, 16'hBEEF, 5'd3);
      drain();
      check("bp_count", 64'(sent_tags.size()), 64'd3);
      for (int i = 0; i < 3; i++)
         if (i < sent_tags.size()) check("bp_order", 64'(sent_tags[i]), 64'(i + 1));

      // flush while full with a simultaneous input
      out_ready = 1'b0;
      put(2'd0, 16'h0044, 5'd4);
      put(2'd0, 16'h0055, 5'd5);
      in_valid = 1'b1; in_tag = 5'd7; in_imm = 16'h0777; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      drain();

      // asynchronous reset pulse between edges
      out_ready = 1'b1;
      put(2'd2, 16'h00AA, 5'd8);
      put(2'd3, 16'h1111, 5'd9);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_out_data", 64'(out_data), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) put(2'(i), IN_W'($urandom), TAG_W'(i + 10));
      drain();

      // narrow configuration
      in_valid2 = 1'b1; in_op2 = 2'd3; in_imm2 = 12'h800; in_tag2 = 3'd1;
      @(posedge clk); #1;
      in_op2 = 2'd2; in_imm2 = 12'hABC; in_tag2 = 3'd2;
      @(negedge clk);
      check("w12_valid", 64'(out_valid2), 64'd1);
      check("w12_op11", 64'(out_data2), 64'h E000);
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      @(negedge clk);
      check("w12_op10", 64'(out_data2), 64'h ABC0);
      check("w12_tag", 64'(out_tag2), 64'd2);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_op     = 2'($urandom_range(0, 3));
         in_imm    = IN_W'($urandom);
         in_tag    = TAG_W'($urandom);
         @(posedge clk); #1;
      end
      flush = 1'b0;
      drain();

`ifdef EXT_PERF_CNT_EN
      rstn = 1'b0;
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      check("perf_reset", 64'(perf_cnt), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) put(2'd0, IN_W'(i), TAG_W'(i));
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("perf_five", 64'(perf_cnt), 64'd5);
      in_valid = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("perf_sat", 64'(perf_cnt), 64'h FFFF);
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension stage for the processor datapath; next generation of the combinational immediate extender.
- Accepts an IN_W-bit immediate, an op code and a tag over a valid/ready handshake.
- Returns the OUT_W-bit extended value one cycle later through a 2-entry skid buffer, so decode/execute backpressure never creates a combinational ready path.
- Adds a branch-offset mode (sign-extend, then shift left 2) and a synchronous flush for pipeline squash.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width; elaboration error if OUT_W < IN_W+2.
- TAG_W, 5, width of the sideband tag carried alongside the value (e.g. destination register).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  stage can accept this cycle.
- in_imm  input  IN_W  immediate.
- in_op  input  2  00 zero-ext, 01 sign-ext, 10 high-position, 11 branch offset.
- in_tag  input  TAG_W  sideband, passed unchanged.
- out_valid  output  1  output holds a result.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  OUT_W  extended value.
- out_tag  output  TAG_W  tag of out_data.

Behaviour:
- Reset (rstn=0, asynchronous): main and skid valid bits cleared; out_valid=0; out_data=0; out_tag=0; in_ready=1 after release.
- Extension function, evaluated at acceptance and stored already extended:
  - 00: zero-fill the upper bits.
  - 01: replicate in_imm[IN_W-1].
  - 10: {in_imm, (OUT_W-IN_W) zeros}.
  - 11: sign-extend to OUT_W, then shift left 2; the upper 2 bits are dropped.
- Handshakes: accept = in_valid & in_ready; send = out_valid & out_ready.
- in_ready = ~skid_valid, a registered signal only with no combinational path from out_ready.
- Latency: data accepted in cycle N appears on out_* in cycle N+1 if main is empty or draining.
- Storage states, by {skid_valid, main_valid}: EMPTY(00), ONE(01), FULL(11).
  - EMPTY: accept -> ONE, data into main.
  - ONE, send & accept: main reloaded with new data, stays ONE.
  - ONE, send only: -> EMPTY.
  - ONE, accept without send: new data into skid -> FULL.
  - ONE, neither: hold.
  - FULL: in_ready=0. On send, skid moves to main -> ONE. Otherwise hold.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.
- out_data and out_tag are stable while out_valid=1 and out_ready=0.
- Flush: on a clock edge with flush=1, all valid bits clear -> EMPTY. An input accept and any send in that same cycle are discarded. Data registers may keep stale values; out_valid=0 qualifies them.
- Simultaneous flush and reset: reset dominates.
- Reset asserted mid-transaction: all entries are lost immediately.

Optional Feature:
- Macro EXT_PERF_CNT_EN.
- With the macro defined:
  - Extra output port perf_cnt, width 16, counts accepted transactions; saturates at 16'hFFFF.
  - Reset value 0 on rstn; not cleared by flush.
  - A transaction accepted in a flush cycle is not counted.
- Without the macro: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Defaults, out_ready=1. Back-to-back ops 00/F000, 01/F000, 10/000F, 11/FFFF -> out_data 0000F000, FFFFF000, 000F0000, FFFFFFFC on consecutive cycles, starting one cycle after the first accept.
- Backpressure: out_ready=0, offer tags 1,2,3 -> tags 1,2 accepted, in_ready falls after the second, tag 3 held. Raise out_ready -> tags 1,2,3 emerge in order with stable data while stalled.
- Flush in FULL state with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears on the output.
- Async reset pulse mid-stream, applied between clock edges -> out_valid=0 and out_data=0 immediately; stream resumes correctly after release.
- Non-default IN_W=12, OUT_W=16: op 11, imm 12'h800 -> 16'hE000; op 10, imm 12'hABC -> 16'hABC0.
- EXT_PERF_CNT_EN defined: 5 accepts plus 1 accept during flush -> perf_cnt=5. Preload or run to 16'hFFFF, then one more accept -> stays 16'hFFFF.
